// File: rtl/flatten_stream.sv
// Flatten stage: buffers one H x W x NUM_CH frame and replays it as a flat
// element stream over valid/ready, in HWC or CHW order.
module flatten_stream #(
  parameter int WIDTH_BIT = 32,
  parameter int H         = 5,
  parameter int W         = 5,
  parameter int NUM_CH    = 4,
  parameter int ORDER     = 0,
  localparam int TOTAL    = H * W * NUM_CH,
  localparam int IW       = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_CH*WIDTH_BIT-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH_BIT-1:0]        out_data,
  output logic [IW-1:0]               out_index,
  output logic                        out_last
);

  // state | meaning
  // FILL  | accepting pixel vectors into the frame buffer
  // DRAIN | streaming buffered elements, input blocked

  localparam int NPIX = H * W;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef enum logic {FILL, DRAIN} state_t;

  state_t               state, state_nxt;
  logic [PW-1:0]        pix_cnt;
  logic [WIDTH_BIT-1:0] mem [TOTAL];
  logic                 in_fire, out_fire, last_pix;
  logic [IW-1:0]        idx_nxt;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last_pix = (pix_cnt == PW'(NPIX - 1));
  assign idx_nxt  = out_index + 1'b1;

  function automatic logic [IW-1:0] flat_idx(input logic [PW-1:0] p, input int c);
    int f;
    if (ORDER == 0) f = int'(p) * NUM_CH + c;
    else            f = c * NPIX + int'(p);
    return IW'(f);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_fire && last_pix) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (out_fire && out_last) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       pix_cnt <= '0;
    else if (in_fire) pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
  end

  // Buffer is intentionally not reset; every frame overwrites all entries.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int c = 0; c < NUM_CH; c++)
        mem[flat_idx(pix_cnt, c)] <= in_data[c*WIDTH_BIT +: WIDTH_BIT];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else if (in_fire && last_pix) begin
      out_valid <= 1'b1;
      out_index <= '0;
      out_last  <= (TOTAL == 1);
      // Element 0 is pixel 0 channel 0; it is only in flight on this beat when the frame is one pixel.
      out_data  <= (NPIX == 1) ? in_data[WIDTH_BIT-1:0] : mem[0];
    end else if (out_fire) begin
      if (out_last) begin
        out_valid <= 1'b0;
        out_index <= '0;
        out_last  <= 1'b0;
      end else begin
        out_index <= idx_nxt;
        out_data  <= mem[idx_nxt];
        out_last  <= (idx_nxt == IW'(TOTAL - 1));
      end
    end
  end

endmodule

// File: tb/tb_flatten_stream.sv
// Randomized scoreboard bench for flatten_stream; an HWC and a CHW instance
// share the same stimulus and are checked against a flat-index reference model.
module tb_flatten_stream;

  localparam int WB = 8;
  localparam int H  = 2;
  localparam int W  = 2;
  localparam int C  = 2;
  localparam int NP = H * W;
  localparam int TOTAL = NP * C;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic [C*WB-1:0] in_data;
  logic            out_ready;

  logic            in_ready0, in_ready1, out_valid0, out_valid1, out_last0, out_last1;
  logic [WB-1:0]   out_data0, out_data1;
  logic [IW-1:0]   out_index0, out_index1;

  always #5 clk = ~clk;

  flatten_stream #(.WIDTH_BIT(WB), .H(H), .W(W), .NUM_CH(C), .ORDER(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_index(out_index0), .out_last(out_last0));

  flatten_stream #(.WIDTH_BIT(WB), .H(H), .W(W), .NUM_CH(C), .ORDER(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_index(out_index1), .out_last(out_last1));

  typedef struct {logic [WB-1:0] d; int idx; bit last;} exp_t;

  exp_t          q[2][$];
  int            starts[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            exp_first = -1;
  int            rmode = 0;
  logic [WB-1:0] cur_px[NP][C];

  logic          ov[2], irdy[2], ol[2];
  logic [WB-1:0] od[2];
  logic [IW-1:0] oi[2];
  assign ov[0] = out_valid0;  assign ov[1] = out_valid1;
  assign irdy[0] = in_ready0; assign irdy[1] = in_ready1;
  assign ol[0] = out_last0;   assign ol[1] = out_last1;
  assign od[0] = out_data0;   assign od[1] = out_data1;
  assign oi[0] = out_index0;  assign oi[1] = out_index1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: element at flat index idx, from the (pixel, channel) definition of each order.
  task automatic push_exp();
    exp_t e;
    for (int idx = 0; idx < TOTAL; idx++) begin
      e.idx = idx;
      e.last = (idx == TOTAL - 1);
      e.d = cur_px[idx / C][idx % C];
      q[0].push_back(e);
      e.d = cur_px[idx % NP][idx / NP];
      q[1].push_back(e);
    end
  endtask

  task automatic set_seq(input int base);
    for (int p = 0; p < NP; p++)
      for (int c = 0; c < C; c++) cur_px[p][c] = WB'(base + p * C + c);
  endtask

  task automatic set_rand();
    for (int p = 0; p < NP; p++)
      for (int c = 0; c < C; c++) cur_px[p][c] = WB'($urandom);
  endtask

  // Called at posedge+1; in_ready is stable for the rest of the cycle.
  task automatic send_frame(input int npix, input int gap_pct);
    for (int p = 0; p < npix; p++) begin
      int budget;
      bit done;
      budget = 200;
      done = 0;
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_data = (C*WB)'($urandom);
        @(posedge clk); #1;
      end
      while (!done) begin
        in_valid = 1'b1;
        if (in_ready0) begin
          in_data = {cur_px[p][1], cur_px[p][0]};
          if (p == 0) starts.push_back(cyc);
          if (p == NP - 1) begin
            push_exp();
            exp_first = cyc + 1;
          end
          done = 1;
        end else begin
          in_data = (C*WB)'($urandom);
          budget--;
          if (budget == 0) begin
            chk("in_ready_timeout", 0, 1);
            done = 1;
          end
        end
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 500;
    while ((q[0].size() != 0 || q[1].size() != 0 || out_valid0 || out_valid1) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    chk("drain_timeout", int'(budget == 0), 0);
  endtask

  initial begin
    int pat;
    pat = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(1));
        default: begin
          out_ready = (pat == 0);
          pat = (pat + 1) % 3;
        end
      endcase
    end
  end

  logic          prev_stall[2], prev_v[2], pl[2];
  logic [WB-1:0] pd[2];
  logic [IW-1:0] pi[2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        prev_stall[k] = 1'b0;
        prev_v[k] = 1'b0;
      end else begin
        exp_t e;
        chk(k == 0 ? "in_ready_hwc" : "in_ready_chw", int'(irdy[k]), int'(!ov[k]));
        if (prev_stall[k]) begin
          chk("hold_valid", int'(ov[k]), 1);
          chk("hold_data", int'(od[k]), int'(pd[k]));
          chk("hold_index", int'(oi[k]), int'(pi[k]));
          chk("hold_last", int'(ol[k]), int'(pl[k]));
        end
        if (ov[k] && !prev_v[k]) chk("first_valid_cycle", cyc, exp_first);
        if (ov[k] && out_ready) begin
          if (q[k].size() == 0) begin
            chk("unexpected_output", int'(oi[k]), -1);
          end else begin
            e = q[k].pop_front();
            chk(k == 0 ? "data_hwc" : "data_chw", int'(od[k]), int'(e.d));
            chk(k == 0 ? "index_hwc" : "index_chw", int'(oi[k]), e.idx);
            chk(k == 0 ? "last_hwc" : "last_chw", int'(ol[k]), int'(e.last));
          end
        end
        prev_stall[k] = ov[k] && !out_ready;
        prev_v[k] = ov[k];
        pd[k] = od[k];
        pi[k] = oi[k];
        pl[k] = ol[k];
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'(out_valid0 | out_valid1), 0);
    chk("rst_data", int'(out_data0 | out_data1), 0);
    chk("rst_index", int'(out_index0 | out_index1), 0);
    chk("rst_last", int'(out_last0 | out_last1), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready0 & in_ready1), 1);
    @(posedge clk); #1;

    // Sequential frame, full throughput
    rmode = 0;
    set_seq(1);
    send_frame(NP, 0);
    wait_drain();

    // Backpressure 1,0,0 pattern
    rmode = 2;
    send_frame(NP, 0);
    wait_drain();

    // Input gaps, random ready, consecutive frames (in_valid held during drain)
    rmode = 1;
    set_seq(1);
    send_frame(NP, 40);
    set_rand();
    send_frame(NP, 40);
    wait_drain();

    // Reset after two beats abandons the partial frame
    rmode = 0;
    set_seq(50);
    send_frame(2, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset_valid", int'(out_valid0 | out_valid1), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_valid", int'(out_valid0 | out_valid1), 0);
    @(posedge clk); #1;
    set_seq(9);
    send_frame(NP, 0);
    wait_drain();

    // Signed extremes, back-to-back frames, period check
    starts.delete();
    cur_px[0][0] = 8'h80; cur_px[0][1] = 8'h7F;
    cur_px[1][0] = 8'h7F; cur_px[1][1] = 8'h80;
    cur_px[2][0] = 8'hFF; cur_px[2][1] = 8'h00;
    cur_px[3][0] = 8'h01; cur_px[3][1] = 8'h80;
    send_frame(NP, 0);
    set_seq(100);
    send_frame(NP, 0);
    wait_drain();
    chk("frame_count", starts.size(), 2);
    if (starts.size() == 2) chk("frame_period", starts[1] - starts[0], NP + TOTAL);

    // Random soak
    for (int n = 0; n < 6; n++) begin
      rmode = $urandom_range(2);
      set_rand();
      send_frame(NP, $urandom_range(50));
    end
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, errors %0d", errors);
    $fatal(1, "timeout");
  end

endmodule
